// File: rtl/shift_xcvr_pkg.sv
// Shared types and helpers for the full-duplex shift engine.
//   xcvr_state_e : engine state (IDLE / SHIFT)
//   cnt_w()      : bit-counter width for a W-bit word
package shift_xcvr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } xcvr_state_e;

  // Width of a counter holding 0..w-1. Clamped to 1 so that w==1 still gives a legal vector.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/tick_cnt.sv
// Modulo-N counter with clear and enable.
//   clk, rst : system clock, async active-high reset
//   clr_i    : force count to 0 (wins over en_i)
//   en_i     : advance by one, wrapping N-1 -> 0
//   cnt_o    : current count
//   last_o   : count == N-1
module tick_cnt
  import shift_xcvr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  output logic [cnt_w(N)-1:0] cnt_o,
  output logic                last_o
);

  localparam int CW = cnt_w(N);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CW'(N - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = last_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shift_xcvr.sv
// Full-duplex serial shift engine: sends one W-bit word on sout_o while capturing
// W bits from sin_i, one bit per tick_i strobe. Everything runs on clk.
//   clk, rst    : system clock, async active-high reset
//   tick_i      : bit-period strobe (one clk per bit)
//   tx_data_i   : word to send, captured on accept (tx_valid_i & tx_ready_o)
//   tx_valid_i  : tx_data_i valid
//   tx_ready_o  : engine accepts a word this cycle
//   sout_o      : serial out, IDLE_LVL while no word is in flight
//   sin_i       : serial in, already synchronous to clk
//   rx_data_o   : last completed received word
//   rx_valid_o  : one-clk pulse when rx_data_o updates
//   busy_o      : word in flight
module shift_xcvr
  import shift_xcvr_pkg::*;
#(
  parameter int   W         = 8,
  parameter bit   LSB_FIRST = 1'b0,
  parameter logic IDLE_LVL  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_i,
  input  logic [W-1:0] tx_data_i,
  input  logic         tx_valid_i,
  output logic         tx_ready_o,
  output logic         sout_o,
  input  logic         sin_i,
  output logic [W-1:0] rx_data_o,
  output logic         rx_valid_o,
  output logic         busy_o
);

  localparam int CW = cnt_w(W);

  xcvr_state_e   state_q, state_d;
  logic [W-1:0]  tx_sh_q, tx_sh_d;
  logic [W-1:0]  rx_sh_q, rx_sh_d;
  logic [W-1:0]  rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic [CW-1:0] bit_cnt;
  logic          last;
  logic          shifting, final_tick, accept;

  assign shifting   = (state_q == SHIFT);
  // W-th tick of a word: the slot where a follow-on word is taken with no idle bit.
  assign final_tick = shifting & tick_i & last;
  assign tx_ready_o = (state_q == IDLE) | final_tick;
  assign accept     = tx_valid_i & tx_ready_o;

  // Counter clears on every accept, so a tick in the accept cycle is ignored and
  // the first bit always lasts a full tick period.
  tick_cnt #(.N(W)) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (shifting & tick_i),
    .cnt_o  (bit_cnt),
    .last_o (last)
  );

  // Bit position is only needed through last; the raw count is kept for probing.
  logic unused_bit_cnt;
  assign unused_bit_cnt = ^bit_cnt;

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_sh_d = tx_data_i;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick_i) begin
          if (LSB_FIRST) begin
            rx_sh_d = {sin_i, rx_sh_q[W-1:1]};
            tx_sh_d = {1'b0, tx_sh_q[W-1:1]};
          end else begin
            rx_sh_d = {rx_sh_q[W-2:0], sin_i};
            tx_sh_d = {tx_sh_q[W-2:0], 1'b0};
          end
          if (last) begin
            // Completed word includes the bit sampled on this tick.
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
            if (accept) tx_sh_d = tx_data_i;
            else        state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign sout_o     = shifting ? (LSB_FIRST ? tx_sh_q[0] : tx_sh_q[W-1]) : IDLE_LVL;
  assign busy_o     = shifting;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule
